// File: rtl/maze_pkg.sv
// Shared types and constants for the maze level engine.
package maze_pkg;

  typedef enum logic [1:0] {S_PLAY, S_CHECK, S_DEAD, S_WIN} state_e;

  localparam logic [11:0] COL_BLACK   = 12'h000;
  localparam logic [11:0] COL_WHITE   = 12'hFFF;
  localparam logic [11:0] COL_GREEN   = 12'h0F0;
  localparam logic [11:0] COL_RED     = 12'hF00;
  localparam logic [11:0] COL_MAGENTA = 12'hF0F;

  localparam logic [10:0] SCREEN_W = 11'd640;
  localparam logic [10:0] SCREEN_H = 11'd480;

  localparam int MAX_RECTS = 8;

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
    logic [9:0] w;
    logic [8:0] h;
  } rect_t;

  // Packed geometry ports are zero-extended to MAX_RECTS entries by the caller.
  function automatic rect_t unpack_rect(input logic [10*MAX_RECTS-1:0] xs,
                                        input logic [9*MAX_RECTS-1:0]  ys,
                                        input logic [10*MAX_RECTS-1:0] ws,
                                        input logic [9*MAX_RECTS-1:0]  hs,
                                        input int idx);
    rect_t r;
    r.x = xs[10*idx +: 10];
    r.y = ys[9*idx +: 9];
    r.w = ws[10*idx +: 10];
    r.h = hs[9*idx +: 9];
    return r;
  endfunction

endpackage

// File: rtl/rect_hit.sv
// Combinational half-open point-in-rectangle test; sums are 11 bits so nothing wraps.
module rect_hit
  import maze_pkg::*;
(
  input  logic [10:0] px,
  input  logic [10:0] py,
  input  rect_t       r,
  output logic        hit
);

  logic [10:0] x_end;
  logic [10:0] y_end;

  assign x_end = {1'b0, r.x} + {1'b0, r.w};
  assign y_end = {2'b0, r.y} + {2'b0, r.h};
  assign hit   = (px >= {1'b0, r.x}) && (px < x_end) &&
                 (py >= {2'b0, r.y}) && (py < y_end);

endmodule

// File: rtl/maze_level.sv
// Maze level engine: draws path/pads/player and moves the player with pre-checked moves.
module maze_level
  import maze_pkg::*;
#(
  parameter int N_RECTS     = 5,
  parameter int STEP        = 5,
  parameter int PLAYER_SIZE = 25,
  parameter int TICK_DIV    = 2_500_000,
  parameter int START_X     = 113,
  parameter int START_Y     = 443,
  parameter int MODE        = 0,
  parameter int FLASH_TICKS = 8
) (
  input  logic                   pixel_clk,
  input  logic                   resetSwitch,
  input  logic [9:0]             col,
  input  logic [8:0]             row,
  input  logic [3:0]             switches,
  input  logic                   restart,
  input  logic [10*N_RECTS-1:0]  rect_x,
  input  logic [10*N_RECTS-1:0]  rect_w,
  input  logic [9*N_RECTS-1:0]   rect_y,
  input  logic [9*N_RECTS-1:0]   rect_h,
  input  logic [9:0]             start_x,
  input  logic [8:0]             start_y,
  input  logic [9:0]             start_w,
  input  logic [8:0]             start_h,
  input  logic [9:0]             goal_x,
  input  logic [8:0]             goal_y,
  input  logic [9:0]             goal_w,
  input  logic [8:0]             goal_h,
  output logic [3:0]             red,
  output logic [3:0]             green,
  output logic [3:0]             blue,
  output logic [9:0]             player_x,
  output logic [8:0]             player_y,
  output logic                   won,
  output logic                   dead,
  output logic [3:0]             deaths
);

  localparam int CW = $clog2(TICK_DIV);
  localparam int FW = (FLASH_TICKS > 1) ? $clog2(FLASH_TICKS) : 1;
  localparam logic [10:0] STEP_W = 11'(STEP);
  localparam logic [10:0] SIZE_W = 11'(PLAYER_SIZE);
  localparam logic [10:0] SIZE_M1 = 11'(PLAYER_SIZE - 1);
  localparam logic [9:0] SPAWN_X = 10'(START_X);
  localparam logic [8:0] SPAWN_Y = 9'(START_Y);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [FW-1:0] flash_q, flash_d;
  logic [9:0]    px_q, px_d;
  logic [8:0]    py_q, py_d;
  logic [10:0]   cand_x_q, cand_x_d, cand_y_q, cand_y_d;
  logic          cand_uf_q, cand_uf_d;
  logic [3:0]    deaths_q, deaths_d;
  logic [11:0]   rgb_q, rgb_d;
  logic          tick;

  rect_t rects [N_RECTS];
  rect_t start_r, goal_r, player_r;

  always_comb begin
    for (int i = 0; i < N_RECTS; i++) begin
      rects[i] = unpack_rect((10*MAX_RECTS)'(rect_x), (9*MAX_RECTS)'(rect_y),
                             (10*MAX_RECTS)'(rect_w), (9*MAX_RECTS)'(rect_h), i);
    end
  end

  assign start_r  = {start_x, start_y, start_w, start_h};
  assign goal_r   = {goal_x, goal_y, goal_w, goal_h};
  assign player_r = {px_q, py_q, 10'(PLAYER_SIZE), 9'(PLAYER_SIZE)};

  // Corner 0 is top-left, 1 top-right, 2 bottom-left, 3 bottom-right of the candidate.
  logic [10:0] corner_x [4];
  logic [10:0] corner_y [4];
  always_comb begin
    corner_x[0] = cand_x_q;           corner_y[0] = cand_y_q;
    corner_x[1] = cand_x_q + SIZE_M1; corner_y[1] = cand_y_q;
    corner_x[2] = cand_x_q;           corner_y[2] = cand_y_q + SIZE_M1;
    corner_x[3] = cand_x_q + SIZE_M1; corner_y[3] = cand_y_q + SIZE_M1;
  end

  logic [3:0][N_RECTS-1:0] corner_rect_hit;
  logic [3:0]              corner_start_hit, corner_goal_hit, corner_ok;
  logic [N_RECTS-1:0]      pix_rect_hit;
  logic                    pix_start_hit, pix_goal_hit, pix_player_hit;

  for (genvar c = 0; c < 4; c++) begin : g_corner
    for (genvar i = 0; i < N_RECTS; i++) begin : g_rect
      rect_hit u_hit (.px(corner_x[c]), .py(corner_y[c]), .r(rects[i]),
                      .hit(corner_rect_hit[c][i]));
    end
    rect_hit u_start (.px(corner_x[c]), .py(corner_y[c]), .r(start_r),
                      .hit(corner_start_hit[c]));
    rect_hit u_goal (.px(corner_x[c]), .py(corner_y[c]), .r(goal_r),
                     .hit(corner_goal_hit[c]));
    assign corner_ok[c] = (|corner_rect_hit[c]) | corner_start_hit[c];
  end

  for (genvar i = 0; i < N_RECTS; i++) begin : g_pix_rect
    rect_hit u_hit (.px({1'b0, col}), .py({2'b0, row}), .r(rects[i]), .hit(pix_rect_hit[i]));
  end
  rect_hit u_pix_start (.px({1'b0, col}), .py({2'b0, row}), .r(start_r), .hit(pix_start_hit));
  rect_hit u_pix_goal (.px({1'b0, col}), .py({2'b0, row}), .r(goal_r), .hit(pix_goal_hit));
  rect_hit u_pix_player (.px({1'b0, col}), .py({2'b0, row}), .r(player_r), .hit(pix_player_hit));

  logic legal, in_goal;
  assign legal   = !cand_uf_q && ((cand_x_q + SIZE_W) <= SCREEN_W) &&
                   ((cand_y_q + SIZE_W) <= SCREEN_H) && (&corner_ok);
  assign in_goal = &corner_goal_hit;
  assign tick    = (cnt_q == CW'(TICK_DIV - 1));
  assign cnt_d   = tick ? '0 : cnt_q + CW'(1);

  always_comb begin
    state_d   = state_q;
    px_d      = px_q;
    py_d      = py_q;
    cand_x_d  = cand_x_q;
    cand_y_d  = cand_y_q;
    cand_uf_d = cand_uf_q;
    deaths_d  = deaths_q;
    flash_d   = flash_q;
    if (restart) begin
      state_d  = S_PLAY;
      px_d     = SPAWN_X;
      py_d     = SPAWN_Y;
      deaths_d = '0;
      flash_d  = '0;
    end else begin
      case (state_q)
        S_PLAY: if (tick && (switches != 4'b0)) begin
          cand_x_d  = {1'b0, px_q};
          cand_y_d  = {2'b0, py_q};
          cand_uf_d = 1'b0;
          if (switches[3]) begin
            cand_x_d  = {1'b0, px_q} - STEP_W;
            cand_uf_d = ({1'b0, px_q} < STEP_W);
          end else if (switches[2]) begin
            cand_y_d  = {2'b0, py_q} - STEP_W;
            cand_uf_d = ({2'b0, py_q} < STEP_W);
          end else if (switches[1]) begin
            cand_y_d = {2'b0, py_q} + STEP_W;
          end else begin
            cand_x_d = {1'b0, px_q} + STEP_W;
          end
          state_d = S_CHECK;
        end
        S_CHECK: begin
          if (legal) begin
            px_d    = cand_x_q[9:0];
            py_d    = cand_y_q[8:0];
            state_d = in_goal ? S_WIN : S_PLAY;
          end else if (MODE == 1) begin
            state_d = S_DEAD;
            flash_d = '0;
            if (deaths_q != 4'd15) deaths_d = deaths_q + 4'd1;
          end else begin
            state_d = S_PLAY;
          end
        end
        S_DEAD: if (tick) begin
          if (flash_q == FW'(FLASH_TICKS - 1)) begin
            state_d = S_PLAY;
            px_d    = SPAWN_X;
            py_d    = SPAWN_Y;
            flash_d = '0;
          end else begin
            flash_d = flash_q + FW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Flash phase picks the dying player's colour: odd ticks red, even ticks magenta.
  always_comb begin
    rgb_d = COL_BLACK;
    if (pix_player_hit)     rgb_d = (state_q == S_DEAD && flash_q[0]) ? COL_RED : COL_MAGENTA;
    else if (pix_start_hit) rgb_d = COL_GREEN;
    else if (pix_goal_hit)  rgb_d = COL_RED;
    else if (|pix_rect_hit) rgb_d = COL_WHITE;
  end

  always_ff @(posedge pixel_clk or negedge resetSwitch) begin
    if (!resetSwitch) begin
      state_q   <= S_PLAY;
      cnt_q     <= '0;
      flash_q   <= '0;
      px_q      <= SPAWN_X;
      py_q      <= SPAWN_Y;
      cand_x_q  <= '0;
      cand_y_q  <= '0;
      cand_uf_q <= 1'b0;
      deaths_q  <= '0;
      rgb_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      flash_q   <= flash_d;
      px_q      <= px_d;
      py_q      <= py_d;
      cand_x_q  <= cand_x_d;
      cand_y_q  <= cand_y_d;
      cand_uf_q <= cand_uf_d;
      deaths_q  <= deaths_d;
      rgb_q     <= rgb_d;
    end
  end

  assign red      = rgb_q[11:8];
  assign green    = rgb_q[7:4];
  assign blue     = rgb_q[3:0];
  assign player_x = px_q;
  assign player_y = py_q;
  assign won      = (state_q == S_WIN);
  assign dead     = (state_q == S_DEAD);
  assign deaths   = deaths_q;

endmodule

// File: tb/tb_maze_level.sv
// Directed bench for maze_level: pixel colour table plus move/death/win/reset sequences.
module tb_maze_level;

  localparam logic [3:0] SW_LEFT = 4'b1000;
  localparam logic [3:0] SW_UP   = 4'b0100;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] col;
  logic [8:0] row;
  logic [3:0] sw [3];
  logic       restart [3];

  logic [19:0] rect_x, rect_w;
  logic [17:0] rect_y, rect_h;

  logic [3:0] red [3], green [3], blue [3], deaths [3];
  logic [9:0] px [3];
  logic [8:0] py [3];
  logic       won [3], dead [3];

  always #5 clk = ~clk;

  assign rect_x = {10'd500, 10'd100};
  assign rect_w = {10'd140, 10'd50};
  assign rect_y = {9'd0, 9'd100};
  assign rect_h = {9'd50, 9'd380};

  // Instance 0: BLOCK mode, 1: RESPAWN mode, 2: BLOCK mode spawned inside the goal.
  for (genvar k = 0; k < 3; k++) begin : g_dut
    maze_level #(
      .N_RECTS(2), .STEP(5), .PLAYER_SIZE(25), .TICK_DIV(4),
      .START_X(k == 2 ? 505 : 113), .START_Y(k == 2 ? 20 : 443),
      .MODE(k == 1 ? 1 : 0), .FLASH_TICKS(8)
    ) u_dut (
      .pixel_clk(clk), .resetSwitch(rst_n), .col(col), .row(row),
      .switches(sw[k]), .restart(restart[k]),
      .rect_x(rect_x), .rect_w(rect_w), .rect_y(rect_y), .rect_h(rect_h),
      .start_x(10'd100), .start_y(9'd430), .start_w(10'd50), .start_h(9'd50),
      .goal_x(10'd500), .goal_y(9'd0), .goal_w(10'd140), .goal_h(9'd50),
      .red(red[k]), .green(green[k]), .blue(blue[k]),
      .player_x(px[k]), .player_y(py[k]), .won(won[k]), .dead(dead[k]), .deaths(deaths[k])
    );
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [9:0]  col;
    logic [8:0]  row;
    logic [11:0] rgb;
  } pix_vec_t;
  pix_vec_t vecs [13];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int rgb(input int k);
    return int'({red[k], green[k], blue[k]});
  endfunction

  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
    cyc += n;
  endtask

  task automatic adv_to(input int target);
    adv(target - cyc);
  endtask

  task automatic do_reset(input logic [3:0] s0, input logic [3:0] s1, input logic [3:0] s2);
    @(negedge clk);
    rst_n = 1'b0;
    sw[0] = s0; sw[1] = s1; sw[2] = s2;
    restart[0] = 1'b0; restart[1] = 1'b0; restart[2] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
  endtask

  initial begin
    vecs[0]  = '{10'd120, 9'd450, 12'hF0F};
    vecs[1]  = '{10'd0,   9'd0,   12'h000};
    vecs[2]  = '{10'd110, 9'd200, 12'hFFF};
    vecs[3]  = '{10'd110, 9'd440, 12'h0F0};
    vecs[4]  = '{10'd520, 9'd10,  12'hF00};
    vecs[5]  = '{10'd149, 9'd479, 12'h0F0};
    vecs[6]  = '{10'd150, 9'd200, 12'h000};
    vecs[7]  = '{10'd137, 9'd467, 12'hF0F};
    vecs[8]  = '{10'd138, 9'd467, 12'h0F0};
    vecs[9]  = '{10'd100, 9'd100, 12'hFFF};
    vecs[10] = '{10'd99,  9'd100, 12'h000};
    vecs[11] = '{10'd639, 9'd49,  12'hF00};
    vecs[12] = '{10'd500, 9'd50,  12'h000};

    rst_n = 1'b0;
    col = 10'd120; row = 9'd450;
    for (int k = 0; k < 3; k++) begin
      sw[k] = 4'b0;
      restart[k] = 1'b0;
    end

    // Reset state
    #22;
    check("rst_rgb0", rgb(0), 0);
    check("rst_x0", px[0], 113);
    check("rst_y0", py[0], 443);
    check("rst_deaths1", deaths[1], 0);
    check("rst_dead1", dead[1], 0);
    check("rst_won2", won[2], 0);
    check("rst_x2", px[2], 505);
    check("rst_y2", py[2], 20);

    // Pixel colour table against the static player at (113, 443)
    do_reset(4'b0, 4'b0, 4'b0);
    for (int i = 0; i < 13; i++) begin
      col = vecs[i].col;
      row = vecs[i].row;
      adv(1);
      check($sformatf("pix%0d", i), rgb(0), int'(vecs[i].rgb));
    end

    // Up held, BLOCK mode: one move per tick, two cycles after the tick
    do_reset(SW_UP, 4'b0, 4'b0);
    adv_to(4);
    check("up_before_y", py[0], 443);
    adv_to(5);
    check("up_first_y", py[0], 438);
    check("up_first_x", px[0], 113);
    adv_to(8);
    check("up_hold_y", py[0], 438);
    adv_to(9);
    check("up_second_y", py[0], 433);

    // Left held: BLOCK stops at 103, RESPAWN dies and later respawns
    do_reset(SW_LEFT, SW_LEFT, 4'b0);
    adv_to(5);
    check("left_x0_a", px[0], 108);
    check("left_x1_a", px[1], 108);
    adv_to(9);
    check("left_x0_b", px[0], 103);
    check("left_x1_b", px[1], 103);
    adv_to(12);
    check("left_dead_early", dead[1], 0);
    adv_to(13);
    check("block_x0", px[0], 103);
    check("block_deaths0", deaths[0], 0);
    check("block_dead0", dead[0], 0);
    check("kill_dead1", dead[1], 1);
    check("kill_deaths1", deaths[1], 1);
    check("kill_x1", px[1], 103);
    col = 10'd110; row = 9'd450;
    adv_to(17);
    check("flash_odd_rgb1", rgb(1), 'hF00);
    adv_to(21);
    check("flash_even_rgb1", rgb(1), 'hF0F);
    adv_to(43);
    check("dead_hold1", dead[1], 1);
    check("dead_hold_x1", px[1], 103);
    adv_to(44);
    check("respawn_dead1", dead[1], 0);
    check("respawn_x1", px[1], 113);
    check("respawn_y1", py[1], 443);
    check("respawn_deaths1", deaths[1], 1);
    check("block_hold_x0", px[0], 103);
    restart[1] = 1'b1;
    adv(1);
    restart[1] = 1'b0;
    check("restart_deaths1", deaths[1], 0);

    // Win: move into goal, freeze, restart beats a simultaneous tick
    do_reset(4'b0, 4'b0, SW_UP);
    adv_to(4);
    check("win_early", won[2], 0);
    adv_to(5);
    check("win_y2", py[2], 15);
    check("win_won2", won[2], 1);
    adv_to(13);
    check("win_frozen_y2", py[2], 15);
    check("win_frozen_x2", px[2], 505);
    adv_to(15);
    restart[2] = 1'b1;
    adv_to(16);
    restart[2] = 1'b0;
    check("restart_won2", won[2], 0);
    check("restart_y2", py[2], 20);
    check("restart_x2", px[2], 505);
    adv_to(17);
    check("restart_beats_tick_y2", py[2], 20);
    adv_to(21);
    check("rewin_y2", py[2], 15);
    check("rewin_won2", won[2], 1);

    // Asynchronous reset while in CHECK
    do_reset(SW_UP, 4'b0, 4'b0);
    col = 10'd120; row = 9'd450;
    adv_to(4);
    check("pre_reset_rgb0", rgb(0), 'hF0F);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rgb0", rgb(0), 0);
    check("async_x0", px[0], 113);
    check("async_y0", py[0], 443);
    check("async_deaths0", deaths[0], 0);
    check("async_won0", won[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    adv_to(4);
    check("discard_y0", py[0], 443);
    adv_to(5);
    check("after_reset_move_y0", py[0], 438);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/maze_level.md
# maze_level

Parametrised maze-level engine: renders N path rectangles, a start pad, a goal pad and a player square onto the VGA pixel stream, and moves the player from the direction switches at a divided tick rate. Moves are pre-checked against the path union before they are committed, instead of being corrected after the fact. Level geometry is supplied on ports, so the top level can swap levels without resynthesis. Sits between the VGA timing generator (col/row) and the colour DAC outputs.

## Interface
Parameters:
- N_RECTS, 5, number of path rectangles (1..8)
- STEP, 5, pixels moved per accepted move
- PLAYER_SIZE, 25, player square side in pixels
- TICK_DIV, 2_500_000, pixel_clk cycles per move tick (≥2)
- START_X, 113 / START_Y, 443, player spawn position (top-left corner)
- MODE, 0, 0 = BLOCK (illegal move ignored), 1 = RESPAWN (illegal move kills the player)
- FLASH_TICKS, 8, ticks spent in DEAD before respawn

Ports:
- pixel_clk  in  1  pixel clock; the only clock
- resetSwitch  in  1  asynchronous, active-low reset
- col  in  10  current pixel column
- row  in  9  current pixel row
- switches  in  4  [3] left, [2] up, [1] down, [0] right
- restart  in  1  single-cycle pulse; respawns the player and clears the death count
- rect_x, rect_w  in  10*N_RECTS  path rectangle x and width, packed; rect i at [10i+9:10i]
- rect_y, rect_h  in  9*N_RECTS  path rectangle y and height, packed
- start_x/start_y/start_w/start_h, goal_x/goal_y/goal_w/goal_h  in  10/9/10/9  pad geometry
- red, green, blue  out  4 each  registered pixel colour
- player_x  out  10 / player_y  out  9  current player position
- won  out  1  high in WIN
- dead  out  1  high in DEAD
- deaths  out  4  death count, saturates at 15

## Operation
- States: PLAY, CHECK, DEAD, WIN. Reset: PLAY, player at (START_X, START_Y), deaths 0, colour 0, tick counter 0.
- The tick counter runs 0..TICK_DIV-1 in every state. `tick` is high for one cycle when the count is TICK_DIV-1.
- PLAY, on tick with any switch set: form the candidate position. Priority is left > up > down > right; only one axis moves. Latch the candidate, then go to CHECK.
- CHECK (one cycle): the candidate is legal only if each of its four corners (x, y), (x+P-1, y), (x, y+P-1), (x+P-1, y+P-1) lies inside at least one path rectangle or the start pad. A subtraction underflow (x<STEP or y<STEP), x+P>640 or y+P>480 is illegal.
  - Legal: commit. If the player then lies fully inside the goal, go to WIN; otherwise go to PLAY.
  - Illegal, MODE 0: keep the position and go to PLAY.
  - Illegal, MODE 1: go to DEAD and increment deaths, saturating at 15.
- DEAD: hold the position. After FLASH_TICKS ticks, load the start position and go to PLAY.
- WIN: switches are ignored and the position is frozen.
- restart in any state: load the start position, clear deaths, go to PLAY. restart beats a simultaneous tick or CHECK.
- Inside tests use half-open intervals: x ≥ rx and x < rx+rw. All sums use 11 bits, so there is no wrap.
- Pixel colour priority:
  1. player: magenta F/0/F; in DEAD, red F/0/0 on odd ticks and magenta on even ticks
  2. start pad: green 0/F/0
  3. goal: red F/0/0
  4. any path rectangle: white F/F/F
  5. otherwise: black
- won and dead are decoded from the state register.

## Timing
- Colour outputs: one-cycle latency from col/row.
- Move: tick in cycle t → CHECK in t+1 → player_x/player_y updated at t+2.
- won and dead assert in the same cycle the position or state commits.
- At most one move per tick. A switch held continuously moves once per tick.
- Reset mid-move discards the latched candidate.

## Structure
- Package maze_pkg holds:
  - the state enum
  - colour constants
  - screen limits 640/480
  - rect_t struct {x, y, w, h}, plus an unpack function for the packed ports
- Sub-module rect_hit: combinational point-in-rectangle test. It is instantiated for the pixel path and for the four corner checks, with a generate loop over N_RECTS.

## Test plan
Common bench setup: TICK_DIV=4, rect0 = (100, 100, 50, 380), start pad = (100, 430, 50, 50), goal = (500, 0, 140, 50).
- Up held, MODE 0 → 2 cycles after the tick, player_y 443→438; player_x stays 113.
- Left held, MODE 0 → x goes 108, then 103, then stays 103 (98<100 is illegal); deaths stays 0.
- Left held, MODE 1 → x goes 108, 103, then dead=1 and deaths=1. After 8 ticks the player is back at (113, 443) and dead=0.
- START_X=505, START_Y=20, goal covering it, up held → player_y=15 and won=1. Further ticks leave the position unchanged. A restart pulse gives (505, 20) with won=0.
- Player at (113, 443) with col=120, row=450 → next cycle colour F/0/F.
  - col=0, row=0 → 0/0/0.
  - col=110, row=200 → F/F/F.
- resetSwitch low in CHECK → all outputs 0 immediately, position back to (113, 443), deaths 0.
